// File: rtl/l2_cache_pkg.sv
// Shared definitions for the L2 write-back cache: FSM state type and
// address-field width helpers (offset / index / tag).
package l2_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESPOND
  } state_e;

  function automatic int offset_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int index_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_width(input int addr_width, input int data_width, input int num_sets);
    return addr_width - offset_width(data_width) - index_width(num_sets);
  endfunction

endpackage

// File: rtl/l2_way_select.sv
// Victim-way selection: lowest-index invalid way, otherwise a per-set
// round-robin pointer that advances on every allocation into the set.
module l2_way_select
  import l2_cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  localparam int IW = index_width(NUM_SETS),
  localparam int WW = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IW-1:0]       set_idx,
  input  logic [NUM_WAYS-1:0] set_valid,
  input  logic                alloc,
  output logic [WW-1:0]       victim
);

  logic [WW-1:0] ptr_q [NUM_SETS];
  logic [WW-1:0] ptr_d [NUM_SETS];
  logic          found;

  always_comb begin
    victim = ptr_q[set_idx];
    found  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !set_valid[w]) begin
        victim = WW'(w);
        found  = 1'b1;
      end
    end
  end

  // Pointer width equals log2(NUM_WAYS), so the increment wraps modulo NUM_WAYS.
  always_comb begin
    ptr_d = ptr_q;
    if (alloc) begin
      ptr_d[set_idx] = ptr_q[set_idx] + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        ptr_q[s] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/l2_cache_wb.sv
// Set-associative, one-word-per-line, write-back / write-allocate L2 cache.
// Optional hit/miss statistics counters enabled by macro L2_CACHE_STATS_EN.
module l2_cache_wb
  import l2_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] l1_cache_addr,
  input  logic [DATA_WIDTH-1:0] l1_cache_data_in,
  output logic [DATA_WIDTH-1:0] l1_cache_data_out,
  input  logic                  l1_cache_read,
  input  logic                  l1_cache_write,
  output logic                  l1_cache_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_ready,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int OW = offset_width(DATA_WIDTH);
  localparam int IW = index_width(NUM_SETS);
  localparam int TW = tag_width(ADDR_WIDTH, DATA_WIDTH, NUM_SETS);
  localparam int WW = $clog2(NUM_WAYS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << OW) - ADDR_WIDTH'(1));

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic                  req_write_q, req_write_d;
  logic [WW-1:0]         way_q, way_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_d [NUM_SETS];
  logic [TW-1:0]         tag_q   [NUM_SETS][NUM_WAYS];
  logic [TW-1:0]         tag_d   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] line_q  [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] line_d  [NUM_SETS][NUM_WAYS];

  logic [IW-1:0]         req_idx;
  logic [TW-1:0]         req_tag;
  logic                  hit;
  logic [WW-1:0]         hit_way;
  logic [WW-1:0]         victim;
  logic                  alloc;
  logic                  fill_en;
  logic                  fill_dirty;
  logic [WW-1:0]         fill_way;
  logic [DATA_WIDTH-1:0] fill_data;

  assign req_idx = req_addr_q[OW +: IW];
  assign req_tag = req_addr_q[ADDR_WIDTH-1 -: TW];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  l2_way_select #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_way_select (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_idx   (req_idx),
    .set_valid (valid_q[req_idx]),
    .alloc     (alloc),
    .victim    (victim)
  );

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_write_d = req_write_q;
    way_d       = way_q;
    data_out_d  = data_out_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    alloc       = 1'b0;
    fill_en     = 1'b0;
    fill_dirty  = 1'b0;
    fill_way    = way_q;
    fill_data   = req_data_q;
    unique case (state_q)
      IDLE: begin
        if (l1_cache_read || l1_cache_write) begin
          req_addr_d  = l1_cache_addr;
          req_data_d  = l1_cache_data_in;
          req_write_d = l1_cache_write;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          state_d = RESPOND;
          if (req_write_q) begin
            fill_en    = 1'b1;
            fill_dirty = 1'b1;
            fill_way   = hit_way;
          end else begin
            data_out_d = line_q[req_idx][hit_way];
          end
        end else begin
          alloc = 1'b1;
          way_d = victim;
          if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
            state_d     = WRITEBACK;
            mem_addr_d  = ADDR_WIDTH'({tag_q[req_idx][victim], req_idx}) << OW;
            mem_wdata_d = line_q[req_idx][victim];
          end else if (req_write_q) begin
            fill_en    = 1'b1;
            fill_dirty = 1'b1;
            fill_way   = victim;
            state_d    = RESPOND;
          end else begin
            state_d    = REFILL;
            mem_addr_d = req_addr_q & LINE_MASK;
          end
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          if (req_write_q) begin
            fill_en    = 1'b1;
            fill_dirty = 1'b1;
            state_d    = RESPOND;
          end else begin
            state_d    = REFILL;
            mem_addr_d = req_addr_q & LINE_MASK;
          end
        end
      end
      REFILL: begin
        if (mem_ready) begin
          fill_en    = 1'b1;
          fill_data  = mem_data_in;
          data_out_d = mem_data_in;
          state_d    = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    line_d  = line_q;
    if (fill_en) begin
      valid_d[req_idx][fill_way] = 1'b1;
      dirty_d[req_idx][fill_way] = fill_dirty;
      tag_d[req_idx][fill_way]   = req_tag;
      line_d[req_idx][fill_way]  = fill_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_write_q <= 1'b0;
      way_q       <= '0;
      data_out_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_write_q <= req_write_d;
      way_q       <= way_d;
      data_out_q  <= data_out_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Tag and data storage is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  assign l1_cache_ready    = (state_q == RESPOND);
  assign mem_read          = (state_q == REFILL);
  assign mem_write         = (state_q == WRITEBACK);
  assign l1_cache_data_out = data_out_q;
  assign mem_addr          = mem_addr_q;
  assign mem_data_out      = mem_wdata_q;

`ifdef L2_CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == LOOKUP) begin
      if (hit && (hit_count_q != '1)) begin
        hit_count_d = hit_count_q + 32'd1;
      end
      if (!hit && (miss_count_q != '1)) begin
        miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l2_cache_wb.sv
// Directed self-checking bench for l2_cache_wb (16 sets, 2 ways, 32-bit),
// with a simple 3-cycle-latency memory model that logs every transaction.
module tb_l2_cache_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] l1_cache_addr = '0;
  logic [31:0] l1_cache_data_in = '0;
  logic [31:0] l1_cache_data_out;
  logic        l1_cache_read = 1'b0;
  logic        l1_cache_write = 1'b0;
  logic        l1_cache_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in = '0;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        mem_log[$];
  logic [31:0] mem_model [logic [31:0]];
  int          total = 0;
  int          bad = 0;

`ifdef L2_CACHE_STATS_EN
  localparam logic [31:0] EXP_HITS   = 32'd1;
  localparam logic [31:0] EXP_MISSES = 32'd1;
`else
  localparam logic [31:0] EXP_HITS   = 32'd0;
  localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

  l2_cache_wb #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_SETS   (16),
    .NUM_WAYS   (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .l1_cache_addr     (l1_cache_addr),
    .l1_cache_data_in  (l1_cache_data_in),
    .l1_cache_data_out (l1_cache_data_out),
    .l1_cache_read     (l1_cache_read),
    .l1_cache_write    (l1_cache_write),
    .l1_cache_ready    (l1_cache_ready),
    .mem_addr          (mem_addr),
    .mem_data_out      (mem_data_out),
    .mem_data_in       (mem_data_in),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_ready         (mem_ready),
    .hit_count         (hit_count),
    .miss_count        (miss_count)
  );

  always #5 clk = ~clk;

  // Memory answers on the third cycle of each request and logs its first cycle.
  initial begin : mem_responder
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_read || mem_write) begin
        if (cnt == 0) begin
          mem_log.push_back('{wr: mem_write, addr: mem_addr, data: mem_data_out});
        end
        cnt++;
        if (cnt == 3) begin
          mem_ready = 1'b1;
          if (mem_write) begin
            mem_model[mem_addr] = mem_data_out;
          end else begin
            mem_data_in = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic rd, input logic wr,
                               output int cycles, output logic [31:0] rdata,
                               output logic got_ready);
    @(negedge clk);
    l1_cache_addr    = addr;
    l1_cache_data_in = wdata;
    l1_cache_read    = rd;
    l1_cache_write   = wr;
    cycles    = 0;
    got_ready = 1'b0;
    rdata     = '0;
    while (!got_ready && cycles < 50) begin
      @(negedge clk);
      cycles++;
      if (l1_cache_ready) begin
        got_ready = 1'b1;
        rdata     = l1_cache_data_out;
      end
    end
    l1_cache_read  = 1'b0;
    l1_cache_write = 1'b0;
  endtask

  initial begin : main
    int          cycles;
    int          base;
    logic [31:0] rdata;
    logic        got;
    logic        seen;

    mem_model[32'h40] = 32'hDEADBEEF;
    mem_model[32'h80] = 32'h80808080;
    mem_model[32'hC0] = 32'hC0C0C0C0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready",    32'(l1_cache_ready), 32'd0);
    checkOutput("rst_mem_read", 32'(mem_read),       32'd0);
    checkOutput("rst_mem_write",32'(mem_write),      32'd0);
    checkOutput("rst_mem_addr", mem_addr,            32'd0);
    checkOutput("rst_mem_data", mem_data_out,        32'd0);
    checkOutput("rst_data_out", l1_cache_data_out,   32'd0);
    checkOutput("rst_hits",     hit_count,           32'd0);
    checkOutput("rst_misses",   miss_count,          32'd0);
    rst_n = 1'b1;

    $display("[TB] cold read of 0x40");
    base = mem_log.size();
    applyStimulus(32'h40, 32'h0, 1'b1, 1'b0, cycles, rdata, got);
    checkOutput("cold_ready", 32'(got), 32'd1);
    checkOutput("cold_data", rdata, 32'hDEADBEEF);
    checkOutput("cold_txns", 32'(mem_log.size() - base), 32'd1);
    if (mem_log.size() > base) begin
      checkOutput("cold_txn_wr",   32'(mem_log[base].wr), 32'd0);
      checkOutput("cold_txn_addr", mem_log[base].addr,    32'h40);
    end

    $display("[TB] re-read of 0x40");
    base = mem_log.size();
    applyStimulus(32'h40, 32'h0, 1'b1, 1'b0, cycles, rdata, got);
    checkOutput("reread_latency", 32'(cycles), 32'd2);
    checkOutput("reread_data", rdata, 32'hDEADBEEF);
    checkOutput("reread_txns", 32'(mem_log.size() - base), 32'd0);
    checkOutput("stats_hits",   hit_count,  EXP_HITS);
    checkOutput("stats_misses", miss_count, EXP_MISSES);

    $display("[TB] dirty eviction sequence");
    base = mem_log.size();
    applyStimulus(32'h40, 32'h11111111, 1'b0, 1'b1, cycles, rdata, got);
    checkOutput("wr40_latency", 32'(cycles), 32'd2);
    checkOutput("wr40_txns", 32'(mem_log.size() - base), 32'd0);

    base = mem_log.size();
    applyStimulus(32'h80, 32'h0, 1'b1, 1'b0, cycles, rdata, got);
    checkOutput("rd80_data", rdata, 32'h80808080);
    checkOutput("rd80_txns", 32'(mem_log.size() - base), 32'd1);
    if (mem_log.size() > base) begin
      checkOutput("rd80_txn_wr",   32'(mem_log[base].wr), 32'd0);
      checkOutput("rd80_txn_addr", mem_log[base].addr,    32'h80);
    end

    base = mem_log.size();
    applyStimulus(32'hC0, 32'h0, 1'b1, 1'b0, cycles, rdata, got);
    checkOutput("rdC0_data", rdata, 32'hC0C0C0C0);
    checkOutput("rdC0_txns", 32'(mem_log.size() - base), 32'd2);
    if (mem_log.size() > base + 1) begin
      checkOutput("rdC0_wb_wr",   32'(mem_log[base].wr),   32'd1);
      checkOutput("rdC0_wb_addr", mem_log[base].addr,      32'h40);
      checkOutput("rdC0_wb_data", mem_log[base].data,      32'h11111111);
      checkOutput("rdC0_rf_wr",   32'(mem_log[base+1].wr), 32'd0);
      checkOutput("rdC0_rf_addr", mem_log[base+1].addr,    32'hC0);
    end

    $display("[TB] simultaneous read+write to 0x44");
    base = mem_log.size();
    applyStimulus(32'h44, 32'hA5A5A5A5, 1'b1, 1'b1, cycles, rdata, got);
    checkOutput("rw44_ready", 32'(got), 32'd1);
    applyStimulus(32'h44, 32'h0, 1'b1, 1'b0, cycles, rdata, got);
    checkOutput("rd44_latency", 32'(cycles), 32'd2);
    checkOutput("rd44_data", rdata, 32'hA5A5A5A5);
    checkOutput("rw44_txns", 32'(mem_log.size() - base), 32'd0);

    $display("[TB] reset during refill");
    @(negedge clk);
    l1_cache_addr = 32'h48;
    l1_cache_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mem_read;
    end
    checkOutput("refill_started", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_mem_read",  32'(mem_read),       32'd0);
    checkOutput("mid_rst_mem_write", 32'(mem_write),      32'd0);
    checkOutput("mid_rst_ready",     32'(l1_cache_ready), 32'd0);
    checkOutput("mid_rst_hits",      hit_count,           32'd0);
    l1_cache_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_mem_read", 32'(mem_read), 32'd0);

    base = mem_log.size();
    applyStimulus(32'h40, 32'h0, 1'b1, 1'b0, cycles, rdata, got);
    checkOutput("post_rst_data", rdata, 32'h11111111);
    checkOutput("post_rst_txns", 32'(mem_log.size() - base), 32'd1);
    if (mem_log.size() > base) begin
      checkOutput("post_rst_txn_wr",   32'(mem_log[base].wr), 32'd0);
      checkOutput("post_rst_txn_addr", mem_log[base].addr,    32'h40);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
